// File: rtl/timer_pkg.sv
// Shared definitions for the countdown-timer field of the VGA clock display.
// Holds the controller state encoding, the cursor codes used by the digit
// renderer for red highlighting, the BCD field limits and BCD step helpers.
package timer_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEdit    = 3'd1,
    StRun     = 3'd2,
    StPause   = 3'd3,
    StExpired = 3'd4
  } state_e;

  // Cursor codes shared with the digit renderer
  localparam logic [3:0] CUR_HR  = 4'd6;
  localparam logic [3:0] CUR_MIN = 4'd7;
  localparam logic [3:0] CUR_SEC = 4'd8;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Nibble-wise BCD increment, wrapping max -> 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Nibble-wise BCD decrement, wrapping 00 -> max
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field (hours, minutes or seconds) of the countdown timer.
// Ports:
//   clk, reset      clock, asynchronous active-low reset (value -> 00)
//   en              step enable; inc/dec are ignored unless set
//   inc, dec        step up/down with wrap at MAX; both together = no change
//   value           registered BCD value
//   borrow_out      combinational pulse when a decrement wraps from 00
module bcd_field_counter
  import timer_pkg::*;
#(
  parameter logic [7:0] MAX = MS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value,
  output logic       borrow_out
);

  logic [7:0] r_value;
  logic       w_step_inc;
  logic       w_step_dec;

  assign w_step_inc = en & inc & ~dec;
  assign w_step_dec = en & dec & ~inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= 8'h00;
    end else if (w_step_inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end else if (w_step_dec) begin
      r_value <= bcd_dec(r_value, MAX);
    end
  end

  // Combinational so the next field can take the borrow on the same edge
  assign borrow_out = w_step_dec & (r_value == 8'h00);
  assign value      = r_value;

endmodule

// File: rtl/timer_control.sv
// Sequencing controller for the countdown-timer field of the VGA clock.
// Edit mode moves a cursor and steps the selected field; otherwise the timer
// runs, pauses and expires from a prescaled once-per-second tick.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   programar_on               level, 1 = edit mode (highest priority)
//   btn_up/down/left/right     single-cycle debounced button pulses
//   start_stop                 single-cycle pulse: start / pause / resume / ack
//   timer_in1/2/3              hours / minutes / seconds, BCD
//   direccion_actual_pantalla  cursor code while editing, else 0
//   running, alarm             countdown active, timer expired
module timer_control
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       programar_on,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       start_stop,
  output logic [7:0] timer_in1,
  output logic [7:0] timer_in2,
  output logic [7:0] timer_in3,
  output logic [3:0] direccion_actual_pantalla,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [3:0]    r_cursor;
  logic [3:0]    w_cursor_nxt;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_dir;
  logic          r_running;
  logic          r_alarm;

  logic       w_edit;
  logic       w_tick;
  logic       w_zero;
  logic       w_last;
  logic       w_sel_hr, w_sel_min, w_sel_sec;
  logic       w_borrow_sec, w_borrow_min, w_borrow_hr;
  logic [7:0] w_hr, w_min, w_sec;

  assign w_edit = (r_state == StEdit);
  // Edit mode pre-empts a tick that would otherwise land on the same edge
  assign w_tick = (r_state == StRun) && !programar_on && (r_presc == TICK_LAST);
  assign w_zero = (w_hr == 8'h00) && (w_min == 8'h00) && (w_sec == 8'h00);
  assign w_last = (w_hr == 8'h00) && (w_min == 8'h00) && (w_sec == 8'h01);

  assign w_sel_hr  = (r_cursor == CUR_HR);
  assign w_sel_min = (r_cursor == CUR_MIN);
  assign w_sel_sec = (r_cursor == CUR_SEC);

  // Edit steps use the current cursor; countdown chains borrows sec -> min -> hr
  bcd_field_counter #(.MAX(MS_MAX)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .en        (w_edit | w_tick),
    .inc       (w_edit & btn_up & w_sel_sec),
    .dec       ((w_edit & btn_down & w_sel_sec) | w_tick),
    .value     (w_sec),
    .borrow_out(w_borrow_sec)
  );

  bcd_field_counter #(.MAX(MS_MAX)) u_min (
    .clk       (clk),
    .reset     (reset),
    .en        (w_edit | w_tick),
    .inc       (w_edit & btn_up & w_sel_min),
    .dec       ((w_edit & btn_down & w_sel_min) | (w_tick & w_borrow_sec)),
    .value     (w_min),
    .borrow_out(w_borrow_min)
  );

  bcd_field_counter #(.MAX(HR_MAX)) u_hr (
    .clk       (clk),
    .reset     (reset),
    .en        (w_edit | w_tick),
    .inc       (w_edit & btn_up & w_sel_hr),
    .dec       ((w_edit & btn_down & w_sel_hr) | (w_tick & w_borrow_min)),
    .value     (w_hr),
    .borrow_out(w_borrow_hr)
  );

  always_comb begin
    w_cursor_nxt = r_cursor;
    if (w_edit && btn_right && !btn_left) begin
      case (r_cursor)
        CUR_HR:  w_cursor_nxt = CUR_MIN;
        CUR_MIN: w_cursor_nxt = CUR_SEC;
        default: w_cursor_nxt = CUR_HR;
      endcase
    end else if (w_edit && btn_left && !btn_right) begin
      case (r_cursor)
        CUR_HR:  w_cursor_nxt = CUR_SEC;
        CUR_SEC: w_cursor_nxt = CUR_MIN;
        default: w_cursor_nxt = CUR_HR;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (programar_on) begin
      w_state_nxt = StEdit;
    end else begin
      unique case (r_state)
        StEdit:    w_state_nxt = StIdle;
        StIdle:    if (start_stop && !w_zero) w_state_nxt = StRun;
        StRun: begin
          if (w_tick && w_last)  w_state_nxt = StExpired;
          else if (start_stop)   w_state_nxt = StPause;
        end
        StPause:   if (start_stop) w_state_nxt = StRun;
        StExpired: if (start_stop) w_state_nxt = StIdle;
        default:   w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cursor  <= CUR_HR;
      r_presc   <= '0;
      r_dir     <= 4'd0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cursor  <= w_cursor_nxt;
      r_dir     <= (w_state_nxt == StEdit) ? w_cursor_nxt : 4'd0;
      r_running <= (w_state_nxt == StRun);
      r_alarm   <= (w_state_nxt == StExpired);
      // Counts on every RUN edge (including the pausing edge); PAUSE holds it
      if (programar_on) begin
        r_presc <= '0;
      end else if (r_state == StRun) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end else if (r_state != StPause) begin
        r_presc <= '0;
      end
    end
  end

  assign timer_in1                 = w_hr;
  assign timer_in2                 = w_min;
  assign timer_in3                 = w_sec;
  assign direccion_actual_pantalla = r_dir;
  assign running                   = r_running;
  assign alarm                     = r_alarm;

  logic w_unused;
  assign w_unused = w_borrow_hr;

endmodule

// File: tb/tb_timer_control.sv
module tb_timer_control;

  logic       clk;
  logic       reset;
  logic       programar_on;
  logic       btn_up, btn_down, btn_left, btn_right, start_stop;
  logic [7:0] timer_in1, timer_in2, timer_in3;
  logic [3:0] direccion_actual_pantalla;
  logic       running, alarm;

  int n_checks = 0;
  int n_pass   = 0;
  logic bad_bcd;

  timer_control #(.TICK_DIV(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .programar_on             (programar_on),
    .btn_up                   (btn_up),
    .btn_down                 (btn_down),
    .btn_left                 (btn_left),
    .btn_right                (btn_right),
    .start_stop               (start_stop),
    .timer_in1                (timer_in1),
    .timer_in2                (timer_in2),
    .timer_in3                (timer_in3),
    .direccion_actual_pantalla(direccion_actual_pantalla),
    .running                  (running),
    .alarm                    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, "_hr"}, timer_in1, h);
    check({tag, "_min"}, timer_in2, m);
    check({tag, "_sec"}, timer_in3, s);
  endtask

  // Inputs change at a falling edge, are sampled at the next rising edge and
  // the results are observed at the falling edge after that.
  task automatic pulse(input logic up, input logic dn, input logic lf, input logic rt,
                       input logic ss);
    btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt; start_stop = ss;
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; start_stop = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 0; programar_on = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; start_stop = 0;
    @(negedge clk);
    check_time("rst", 8'h00, 8'h00, 8'h00);
    check("rst_dir", 8'(direccion_actual_pantalla), 8'd0);
    check("rst_running", 8'(running), 8'd0);
    check("rst_alarm", 8'(alarm), 8'd0);
    reset = 1;
    @(negedge clk);

    // Edit wrap
    programar_on = 1;
    @(negedge clk);
    check("edit_dir6", 8'(direccion_actual_pantalla), 8'd6);
    pulse(0, 1, 0, 0, 0);
    check("hr_dec_wrap", timer_in1, 8'h23);
    pulse(0, 0, 0, 1, 0);
    check("dir7", 8'(direccion_actual_pantalla), 8'd7);
    pulse(1, 0, 0, 0, 0);
    check("min_inc1", timer_in2, 8'h01);
    bad_bcd = 0;
    for (int i = 0; i < 59; i++) begin
      pulse(1, 0, 0, 0, 0);
      if (timer_in2[3:0] > 4'd9 || timer_in2[7:4] > 4'd5) bad_bcd = 1;
    end
    check("min_wrap", timer_in2, 8'h00);
    check("min_bcd_legal", 8'(bad_bcd), 8'd0);

    // Cursor movement
    pulse(0, 0, 1, 0, 0);
    check("left_7to6", 8'(direccion_actual_pantalla), 8'd6);
    pulse(0, 0, 1, 0, 0);
    check("left_6to8", 8'(direccion_actual_pantalla), 8'd8);
    pulse(0, 0, 1, 0, 0);
    check("left_8to7", 8'(direccion_actual_pantalla), 8'd7);
    pulse(0, 0, 0, 1, 0);
    check("right_7to8", 8'(direccion_actual_pantalla), 8'd8);
    pulse(0, 0, 0, 1, 0);
    check("right_8to6", 8'(direccion_actual_pantalla), 8'd6);
    pulse(0, 0, 1, 1, 0);
    check("left_right_nop", 8'(direccion_actual_pantalla), 8'd6);
    pulse(1, 1, 0, 0, 0);
    check("up_down_nop", timer_in1, 8'h23);
    programar_on = 0;
    @(negedge clk);
    check("exit_dir0", 8'(direccion_actual_pantalla), 8'd0);

    // Set 01:00:00 and count down with borrow
    programar_on = 1;
    @(negedge clk);
    check("cursor_kept", 8'(direccion_actual_pantalla), 8'd6);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    programar_on = 0;
    @(negedge clk);
    check_time("set1h", 8'h01, 8'h00, 8'h00);
    pulse(0, 0, 0, 0, 1);
    check("run_entry", 8'(running), 8'd1);
    cycles(3);
    check_time("pre_tick", 8'h01, 8'h00, 8'h00);
    cycles(1);
    check_time("tick1", 8'h00, 8'h59, 8'h59);
    cycles(4);
    check_time("tick2", 8'h00, 8'h59, 8'h58);
    check("run_still", 8'(running), 8'd1);

    // Edit out of RUN; combined move + up uses the old cursor
    programar_on = 1;
    @(negedge clk);
    check("edit_stops_run", 8'(running), 8'd0);
    pulse(0, 0, 0, 1, 0);
    pulse(1, 0, 0, 1, 0);
    check("move_up_min", timer_in2, 8'h00);
    check("move_up_dir", 8'(direccion_actual_pantalla), 8'd8);
    repeat (4) pulse(1, 0, 0, 0, 0);
    programar_on = 0;
    @(negedge clk);
    check_time("set2s", 8'h00, 8'h00, 8'h02);

    // Expire
    pulse(0, 0, 0, 0, 1);
    cycles(4);
    check("exp_sec1", timer_in3, 8'h01);
    cycles(4);
    check_time("expired", 8'h00, 8'h00, 8'h00);
    check("exp_alarm", 8'(alarm), 8'd1);
    check("exp_running", 8'(running), 8'd0);
    cycles(8);
    check_time("no_underflow", 8'h00, 8'h00, 8'h00);
    check("alarm_held", 8'(alarm), 8'd1);
    pulse(0, 0, 0, 0, 1);
    check("alarm_ack", 8'(alarm), 8'd0);
    pulse(0, 0, 0, 0, 1);
    check("zero_start_ignored", 8'(running), 8'd0);

    // Pause / resume
    programar_on = 1;
    @(negedge clk);
    repeat (5) pulse(1, 0, 0, 0, 0);
    programar_on = 0;
    @(negedge clk);
    check("set5s", timer_in3, 8'h05);
    pulse(0, 0, 0, 0, 1);
    cycles(1);
    pulse(0, 0, 0, 0, 1);
    check("paused", 8'(running), 8'd0);
    cycles(10);
    check("frozen", timer_in3, 8'h05);
    pulse(0, 0, 0, 0, 1);
    check("resumed", 8'(running), 8'd1);
    cycles(1);
    check("resume_hold", timer_in3, 8'h05);
    cycles(1);
    check("resume_tick", timer_in3, 8'h04);

    // start_stop on the tick cycle
    cycles(3);
    pulse(0, 0, 0, 0, 1);
    check("coinc_dec", timer_in3, 8'h03);
    check("coinc_pause", 8'(running), 8'd0);
    cycles(4);
    check("coinc_frozen", timer_in3, 8'h03);

    // Asynchronous reset between edges while running
    pulse(0, 0, 0, 0, 1);
    cycles(2);
    #2 reset = 0;
    #1;
    check_time("async_rst", 8'h00, 8'h00, 8'h00);
    check("async_running", 8'(running), 8'd0);
    check("async_alarm", 8'(alarm), 8'd0);
    check("async_dir", 8'(direccion_actual_pantalla), 8'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    pulse(0, 0, 0, 0, 1);
    check("post_rst_start", 8'(running), 8'd0);
    cycles(5);
    check("post_rst_idle", 8'(running), 8'd0);
    check("post_rst_sec", timer_in3, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_control.md
Name: timer_control

Overview:
- Sequencing controller for the countdown-timer field of the VGA clock display.
- Owns the three BCD timer registers (hours, minutes, seconds) that feed the timer digit renderer.
- In programming mode it moves an edit cursor and increments/decrements the selected field. Otherwise it runs, pauses and expires the countdown from a prescaled 1 Hz tick.
- Drives the timer BCD bytes, the cursor address used for red highlighting, and an alarm flag.

Parameters:
- TICK_DIV, 100000000, clk cycles per countdown second. Must be ≥2; benches use 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- programar_on  in  1  level; 1 = edit mode
- btn_up  in  1  single-cycle pulse, already debounced
- btn_down  in  1  single-cycle pulse
- btn_left  in  1  single-cycle pulse
- btn_right  in  1  single-cycle pulse
- start_stop  in  1  single-cycle pulse
- timer_in1  out  8  hours BCD {tens,units}, 00–23
- timer_in2  out  8  minutes BCD, 00–59
- timer_in3  out  8  seconds BCD, 00–59
- direccion_actual_pantalla  out  4  cursor code: 6 = hours, 7 = minutes, 8 = seconds; 0 when not editing
- running  out  1  countdown active
- alarm  out  1  timer expired

Behaviour:
- Reset (reset=0, async) values:
  - timer_in1/2/3 = 8'h00
  - cursor = 6
  - direccion_actual_pantalla = 0
  - running = 0, alarm = 0
  - prescaler = 0, state = IDLE
- All outputs are registered. Each update appears on the clock edge after the cycle in which the causing event is sampled.
- States: IDLE, EDIT, RUN, PAUSE, EXPIRED.
- programar_on=1 has priority and forces EDIT from any state next cycle:
  - running ← 0, alarm ← 0.
  - The prescaler is cleared.
- EDIT:
  - direccion_actual_pantalla = cursor.
  - btn_right: cursor 6→7→8→6. btn_left: cursor 6→8→7→6.
  - btn_up increments the selected field with wrap: hours 23→00, min/sec 59→00.
  - btn_down decrements with wrap: 00→23 for hours, 00→59 for min/sec.
  - btn_up and btn_down in the same cycle: no change. btn_left and btn_right in the same cycle: no change. A move and an up/down in the same cycle both apply; the field change uses the old cursor.
  - start_stop is ignored.
  - programar_on falling → IDLE. Cursor is retained, direccion_actual_pantalla ← 0.
- IDLE:
  - start_stop with a nonzero time → RUN, running ← 1.
  - start_stop with time 00:00:00 is ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. tick is asserted on the cycle count = TICK_DIV-1, and the count wraps to 0.
  - The first decrement lands exactly TICK_DIV cycles after the RUN-entry edge.
  - On tick, decrement with BCD borrow:
    - seconds 00→59 with borrow into minutes;
    - minutes 00→59 with borrow into hours;
    - hours only decrement on borrow.
  - A tick that produces 00:00:00 → EXPIRED the same edge: running ← 0, alarm ← 1.
  - start_stop → PAUSE, running ← 0. The prescaler is held, not cleared.
  - If start_stop and tick coincide, the decrement happens and the state → PAUSE.
- PAUSE:
  - start_stop → RUN and resumes the prescaler from its held value.
  - The time is frozen.
- EXPIRED:
  - alarm stays 1 and the time stays 00:00:00.
  - start_stop → IDLE, alarm ← 0.
- BCD invariant: every nibble is ≤9, and the fields never hold illegal values. Arithmetic is nibble-wise with carry/borrow between units and tens, not binary.
- The prescaler width is clog2(TICK_DIV). The prescaler is cleared in IDLE, EDIT and EXPIRED.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding constants;
  - cursor codes 6/7/8 (shared with the digit renderer);
  - field limits HR_MAX=8'h23 and MS_MAX=8'h59.
- One sub-module, bcd_field_counter. Parameter MAX (BCD). Inputs: inc, dec, load-style enable. Outputs: the registered 8-bit BCD value and a borrow_out pulse generated on the dec from 00.
- Three instances are chained by borrow for the countdown. Edit-mode inc/dec pulses are steered to the instance selected by the cursor.

Test Plan:
- Edit wrap: reset; programar_on=1; btn_down once on cursor 6 → timer_in1=8'h23. btn_right, btn_up ×60 → timer_in2 returns to 8'h00 with no non-BCD value seen.
- Cursor: programar_on=1; btn_left → direccion=8, btn_left → 7, btn_right ×2 → 6. Then programar_on=0 → direccion=0.
- Countdown with borrow (TICK_DIV=4): set 01:00:00, start_stop → after 4 cycles 00:59:59, after 8 cycles 00:59:58, running=1.
- Expire: set 00:00:02, start → 2 ticks later 00:00:00, alarm=1, running=0. Extra ticks cause no underflow. start_stop → alarm=0, IDLE.
- Pause/resume and coincidence: start, pause after 2 cycles, hold 10 cycles with time frozen, resume → next decrement 2 cycles later. start_stop on a tick cycle → decrement applied and PAUSE.
- Async reset mid-RUN: assert reset between edges → all outputs zero immediately. start_stop at 00:00:00 → stays IDLE, running=0.
